// File: rtl/cart_loader_pkg.sv
// Shared types and constants for the cartridge download front-end.
package cart_loader_pkg;

    typedef enum logic [1:0] {SYNC, IDLE, BUSY} ld_state_t;

    localparam logic [7:0] CODE_IDX_DEF = 8'hFF;
    localparam logic [4:0] GG_IDX_DEF   = 5'd2;
    localparam int         HDR_BYTES    = 512;

    // Cheat byte n -> lsb of its lane: fields flags/addr/cmp/repl from the top, bytes little-endian.
    function automatic int lane_lsb(input logic [3:0] n);
        return 96 - 32 * int'(n[3:2]) + 8 * int'(n[1:0]);
    endfunction

endpackage

// File: rtl/cart_loader_if.sv
// ioctl byte stream and sdram toggle-handshake write port, grouped as one bus.
interface cart_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [23:0] rom_waddr;
    logic [7:0]  rom_din;
    logic        rom_wr;
    logic        rom_wrack;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_wrack,
        output ioctl_wait, rom_waddr, rom_din, rom_wr
    );
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_wrack,
        input  ioctl_wait, rom_waddr, rom_din, rom_wr
    );
endinterface

// File: rtl/cart_loader_cheat_capture.sv
// Assembles a 16-byte cheat record from code-index ioctl writes; strobe bit 128 follows byte 15.
module cheat_capture
    import cart_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [3:0]   idx_i,
    input  logic [7:0]   data_i,
    output logic [128:0] gg_code_o
);

    logic [15:0][7:0] lane_q;
    logic             stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= wr_i && (idx_i == 4'hF);
            if (wr_i) lane_q[idx_i] <= data_i;
        end
    end

    assign gg_code_o[128] = stb_q;

    for (genvar n = 0; n < 16; n++) begin : g_lane
        localparam int LSB = lane_lsb(4'(n));
        assign gg_code_o[LSB +: 8] = lane_q[n];
    end

endmodule

// File: rtl/cart_loader.sv
// Cartridge download front-end: ioctl bytes -> toggle-handshake sdram writes, plus ROM mask/header/GG flags.
// Optional cheat-record capture is built when CHEAT_CAPTURE_EN is defined.
module cart_loader
    import cart_loader_pkg::*;
#(
    parameter logic [7:0] CODE_IDX = CODE_IDX_DEF,
    parameter logic [4:0] GG_IDX   = GG_IDX_DEF
) (
    input  logic          clk_sys,
    input  logic          RESET_n,
    cart_loader_if.slave  bus,
    output logic          cart_download,
    output logic [21:0]   cart_mask,
    output logic [21:0]   cart_mask512,
    output logic          cart_sz512,
    output logic          gg,
    output logic          overrun
`ifdef CHEAT_CAPTURE_EN
    , output logic [128:0] gg_code
`endif
);

    ld_state_t   state_q;
    logic        wait_q, wr_q, dl_q, skip_q, ovr_q, sz512_q, gg_q;
    logic [23:0] waddr_q;
    logic [7:0]  din_q;
    logic [21:0] mask_q, mask512_q, mask_d, mask512_d;
    logic        dl_rise, dl_fall, cart_wr, ack;

    assign cart_download = bus.ioctl_download & (bus.ioctl_index != CODE_IDX);
    assign dl_rise       = cart_download & ~dl_q;
    assign dl_fall       = ~cart_download & dl_q;
    assign cart_wr       = cart_download & bus.ioctl_wr;
    assign ack           = (bus.rom_wrack == wr_q);

    always_comb begin
        mask_d    = (bus.ioctl_addr == '0) ? '0 : (mask_q | bus.ioctl_addr[21:0]);
        mask512_d = (bus.ioctl_addr == 25'(HDR_BYTES)) ? '0
                  : (mask512_q | (bus.ioctl_addr[21:0] - 22'(HDR_BYTES)));
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= SYNC;
            wait_q    <= 1'b0;
            wr_q      <= 1'b0;
            dl_q      <= 1'b0;
            skip_q    <= 1'b0;
            ovr_q     <= 1'b0;
            sz512_q   <= 1'b0;
            gg_q      <= 1'b0;
            waddr_q   <= '0;
            din_q     <= '0;
            mask_q    <= '0;
            mask512_q <= '0;
        end else begin
            dl_q <= cart_download;
            if (dl_fall) sz512_q <= bus.ioctl_addr[9];
            if (dl_rise) ovr_q <= 1'b0;
            case (state_q)
                SYNC: begin
                    wr_q    <= bus.rom_wrack;
                    if (dl_rise) waddr_q <= '0;
                    state_q <= IDLE;
                end
                IDLE: begin
                    if (dl_rise) waddr_q <= '0;
                    if (cart_wr) begin
                        din_q     <= bus.ioctl_dout;
                        wr_q      <= ~wr_q;
                        wait_q    <= 1'b1;
                        mask_q    <= mask_d;
                        mask512_q <= mask512_d;
                        gg_q      <= (bus.ioctl_index[4:0] == GG_IDX);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cart_wr) ovr_q <= 1'b1;
                    // A restart seen while the ack was pending keeps the address at 0.
                    if (ack) begin
                        wait_q  <= 1'b0;
                        skip_q  <= 1'b0;
                        waddr_q <= (dl_rise || skip_q) ? '0 : waddr_q + 24'd1;
                        state_q <= IDLE;
                    end else if (dl_rise) begin
                        waddr_q <= '0;
                        skip_q  <= 1'b1;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.rom_waddr  = waddr_q;
    assign bus.rom_din    = din_q;
    assign bus.rom_wr     = wr_q;
    assign cart_mask      = mask_q;
    assign cart_mask512   = mask512_q;
    assign cart_sz512     = sz512_q;
    assign gg             = gg_q;
    assign overrun        = ovr_q;

`ifdef CHEAT_CAPTURE_EN
    cheat_capture u_cheat (
        .clk       (clk_sys),
        .rst_n     (RESET_n),
        .wr_i      (bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_index == CODE_IDX)),
        .idx_i     (bus.ioctl_addr[3:0]),
        .data_i    (bus.ioctl_dout),
        .gg_code_o (gg_code)
    );
`endif

endmodule
